// File: rtl/banked_ram_pkg.sv
// Shared constants and elaboration-time parameter checks for the banked RAM.
package banked_ram_pkg;

    localparam int BYTE_WIDTH = 8;

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

    // Every derived width assumes these shapes, so reject anything else up front.
    function automatic bit params_ok(input int np, input int nb, input int aw,
                                     input int dw, input int mb);
        return (np >= 1) && is_pow2(nb) && (dw > 0) && (dw % BYTE_WIDTH == 0)
            && is_pow2(dw / BYTE_WIDTH) && is_pow2(mb)
            && ((aw >= 31) || (mb <= (1 << aw)))
            && (mb % (nb * (dw / BYTE_WIDTH)) == 0);
    endfunction

endpackage

// File: rtl/banked_ram_bank.sv
// One byte-enabled single-port bank: registered read, read-before-write on the same row.
module banked_ram_bank
    import banked_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ROWS       = 256,
    localparam int ROW_W     = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int BYTES     = DATA_WIDTH / BYTE_WIDTH
) (
    input  logic                  clk,
    input  logic                  i_en,
    input  logic                  i_we,
    input  logic [BYTES-1:0]      i_be,
    input  logic [ROW_W-1:0]      i_row,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [ROWS];
    logic [DATA_WIDTH-1:0] r_rdata;

    // The read samples the old row content even when the same access writes it.
    always_ff @(posedge clk) begin
        if (i_en) begin
            r_rdata <= r_mem[i_row];
            if (i_we) begin
                for (int b = 0; b < BYTES; b++) begin
                    if (i_be[b]) begin
                        r_mem[i_row][b*BYTE_WIDTH +: BYTE_WIDTH] <= i_wdata[b*BYTE_WIDTH +: BYTE_WIDTH];
                    end
                end
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/banked_sp_ram.sv
// Word-interleaved banked RAM: N ports share B single-port banks, round-robin per bank.
module banked_sp_ram
    import banked_ram_pkg::*;
#(
    parameter int NUM_PORTS  = 2,
    parameter int NUM_BANKS  = 4,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_BYTES  = 4096
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic [NUM_PORTS-1:0]                       req_i,
    input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]       addr_i,
    input  logic [NUM_PORTS-1:0]                       we_i,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH/8-1:0]     be_i,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]       wdata_i,
    output logic [NUM_PORTS-1:0]                       gnt_o,
    output logic [NUM_PORTS-1:0]                       rvalid_o,
    output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]       rdata_o
);

    localparam int BYTES    = DATA_WIDTH / BYTE_WIDTH;
    localparam int OFF      = $clog2(BYTES);
    localparam int BANK_W   = $clog2(NUM_BANKS);
    localparam int ROWS     = MEM_BYTES / (NUM_BANKS * BYTES);
    localparam int ROW_BITS = $clog2(ROWS);
    localparam int BANK_IW  = (BANK_W > 0) ? BANK_W : 1;
    localparam int ROW_IW   = (ROW_BITS > 0) ? ROW_BITS : 1;
    localparam int PTR_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    generate
        if (!params_ok(NUM_PORTS, NUM_BANKS, ADDR_WIDTH, DATA_WIDTH, MEM_BYTES)) begin : g_bad_params
            $error("banked_sp_ram: illegal parameter combination");
        end
    endgenerate

    logic [NUM_PORTS-1:0][BANK_IW-1:0]    w_port_bank;
    logic [NUM_PORTS-1:0][ROW_IW-1:0]     w_port_row;
    logic [NUM_BANKS-1:0][NUM_PORTS-1:0]  w_bank_gnt;
    logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] w_bank_rdata;
    logic                                 w_unused_addr;

    // Byte offset and bits above the row index are don't-care: addresses wrap.
    assign w_unused_addr = ^addr_i;

    genvar gi;
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_decode
        if (BANK_W > 0) begin : g_bank_bits
            assign w_port_bank[gi] = addr_i[gi][OFF +: BANK_IW];
        end else begin : g_one_bank
            assign w_port_bank[gi] = '0;
        end
        if (ROW_BITS > 0) begin : g_row_bits
            assign w_port_row[gi] = addr_i[gi][OFF + BANK_W +: ROW_IW];
        end else begin : g_one_row
            assign w_port_row[gi] = '0;
        end
    end

    for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
        logic [NUM_PORTS-1:0]  w_req;
        logic [NUM_PORTS-1:0]  w_gnt;
        logic [PTR_W-1:0]      w_win;
        logic [PTR_W-1:0]      r_ptr;
        logic                  w_we;
        logic [BYTES-1:0]      w_be;
        logic [ROW_IW-1:0]     w_row;
        logic [DATA_WIDTH-1:0] w_wdata;

        always_comb begin
            w_req = '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                w_req[p] = req_i[p] && (w_port_bank[p] == BANK_IW'(gi));
            end
        end

        // Scan from the priority pointer; gating on rst_n keeps gnt low and blocks writes in reset.
        always_comb begin
            int p;
            p     = 0;
            w_gnt = '0;
            w_win = '0;
            if (rst_n) begin
                for (int k = 0; k < NUM_PORTS; k++) begin
                    p = int'(r_ptr) + k;
                    if (p >= NUM_PORTS) p = p - NUM_PORTS;
                    if (w_req[p] && (w_gnt == '0)) begin
                        w_gnt[p] = 1'b1;
                        w_win    = PTR_W'(p);
                    end
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_ptr <= '0;
            end else if (|w_gnt) begin
                r_ptr <= (w_win == PTR_W'(NUM_PORTS - 1)) ? '0 : w_win + PTR_W'(1);
            end
        end

        always_comb begin
            w_we    = 1'b0;
            w_be    = '0;
            w_row   = '0;
            w_wdata = '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (w_gnt[p]) begin
                    w_we    = we_i[p];
                    w_be    = be_i[p];
                    w_row   = w_port_row[p];
                    w_wdata = wdata_i[p];
                end
            end
        end

        assign w_bank_gnt[gi] = w_gnt;

        banked_ram_bank #(
            .DATA_WIDTH(DATA_WIDTH),
            .ROWS      (ROWS)
        ) u_bank (
            .clk    (clk),
            .i_en   (|w_gnt),
            .i_we   (w_we),
            .i_be   (w_be),
            .i_row  (w_row),
            .i_wdata(w_wdata),
            .o_rdata(w_bank_rdata[gi])
        );
    end

    always_comb begin
        gnt_o = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            gnt_o = gnt_o | w_bank_gnt[b];
        end
    end

    logic [NUM_PORTS-1:0]              r_rvalid;
    logic [NUM_PORTS-1:0]              r_is_read;
    logic [NUM_PORTS-1:0][BANK_IW-1:0] r_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rvalid  <= '0;
            r_is_read <= '0;
            r_sel     <= '0;
        end else begin
            r_rvalid  <= gnt_o;
            r_is_read <= gnt_o & ~we_i;
            r_sel     <= w_port_bank;
        end
    end

    assign rvalid_o = r_rvalid;

    always_comb begin
        rdata_o = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (r_rvalid[p] && r_is_read[p]) rdata_o[p] = w_bank_rdata[r_sel[p]];
        end
    end

endmodule

// File: doc/banked_sp_ram.md
# banked_sp_ram

Multi-port, word-interleaved banked RAM with per-bank round-robin arbitration. It is the generalised successor of the byte-enabled single-port RAM: N masters share B single-port banks through a req/gnt/rvalid handshake. It sits between the core/debug/DMA data ports and on-chip data memory, and lets masters hitting different banks proceed in the same cycle.

## Interface
- NUM_PORTS, 2: number of master ports (≥1).
- NUM_BANKS, 4: number of banks (power of two, ≥1).
- ADDR_WIDTH, 16: byte-address width per port.
- DATA_WIDTH, 32: word width (multiple of 8).
- MEM_BYTES, 4096: total capacity in bytes (power of two, ≤2^ADDR_WIDTH, divisible by NUM_BANKS*DATA_WIDTH/8).
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_i  in  [NUM_PORTS]  request per port.
- addr_i  in  [NUM_PORTS][ADDR_WIDTH]  byte address.
- we_i  in  [NUM_PORTS]  1 = write, 0 = read.
- be_i  in  [NUM_PORTS][DATA_WIDTH/8]  byte enables (writes only).
- wdata_i  in  [NUM_PORTS][DATA_WIDTH]  write data.
- gnt_o  out  [NUM_PORTS]  grant, combinational from req_i and arbiter state.
- rvalid_o  out  [NUM_PORTS]  response valid, one cycle after grant.
- rdata_o  out  [NUM_PORTS][DATA_WIDTH]  read data, valid with rvalid_o.

## Operation
- Address decode: OFF = log2(DATA_WIDTH/8) bits ignored; bank = addr[OFF +: log2(NUM_BANKS)]; row = next log2(MEM_BYTES/(NUM_BANKS*DATA_WIDTH/8)) bits. Higher bits are ignored, so addresses wrap modulo MEM_BYTES.
- Per bank: round-robin among ports requesting it. A priority pointer names the highest-priority port. After a grant, the pointer moves to winner+1 mod NUM_PORTS. With no grant it holds.
- Ports on different banks are all granted in the same cycle.
- A granted write updates only the bytes with be_i set. be_i = 0 is a legal no-op write that still produces rvalid.
- A granted read returns the row content from before any write in that cycle. Only one access per bank per cycle exists.
- Every grant, read or write, produces exactly one rvalid_o pulse on the same port in the next cycle.
- rdata_o carries read data for reads. It is 0 for write responses and whenever rvalid_o = 0.
- Masters hold req_i/addr_i/we_i/be_i/wdata_i stable until gnt_o. A dropped un-granted request is legal and has no side effect.
- A port may issue a new request in the cycle its previous rvalid_o is high, giving one access per cycle per port.

## Timing
- Reset values: gnt_o = 0 (forced while rst_n = 0), rvalid_o = 0, rdata_o = 0, all priority pointers = port 0. Memory contents are not reset.
- Latency: gnt_o in cycle T (combinational), rvalid_o/rdata_o registered in T+1. Throughput is 1 access/cycle/bank.
- Combinational path: req_i/addr_i → gnt_o only. rdata_o is muxed from registered bank-select and registered port-valid state.
- Reset asserted at any point: pending rvalid_o is cleared immediately and that response is lost. No write occurs in any cycle where rst_n = 0.
- After reset release, the first cycle behaves exactly as post-reset: port 0 wins every bank it contends for.
- Simultaneous events: grant and rvalid on the same port in the same cycle are independent and both are legal.

## Structure
- Shared package banked_ram_pkg: BYTE_WIDTH = 8 and the parameter legality checks (elaboration-time assertions on power-of-two and divisibility).
- Derived widths (OFF, bank-index, row-index) are localparams in the module.
- One sub-module, banked_ram_bank: a single byte-enabled bank with one-cycle read latency and read-before-write. It is instantiated NUM_BANKS times in a generate loop.
- Arbitration, grant fan-out and the response mux are in the top.

## Test plan
All scenarios use defaults: bank = addr[3:2].
- Port0 write 0xDEADBEEF to 0x0010, be = 1111, then read 0x0010 → gnt same cycle, rvalid next cycle, rdata 0xDEADBEEF. The write response has rdata 0.
- Over 0xDEADBEEF, write 0x11223344 with be = 0101, then read → 0xDE22BE44.
- Both ports request bank 1 continuously (0x0004 and 0x0014) → grants alternate port0, port1, port0, port1. Each rvalid follows its grant by one cycle.
- Port0 0x0000 and port1 0x0004 in the same cycle → both granted, both rvalid next cycle with correct data.
- Write 0xCAFEF00D to 0x0000, read 0x1000 → 0xCAFEF00D (wrap). Port0 reads 0x0020 while port1 drops a non-granted write to 0x0020 → memory unchanged.
- Pulse rst_n low in the cycle after a grant → rvalid_o and rdata_o 0 immediately. After release, a port0/port1 conflict on bank 2 grants port0 first.
